instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder_pkg.sv | 109 ++++++++++
 rtl/encoder_fifo.sv | 81 ++++++++
 rtl/instruction_encoder.sv | 178 +++++++++++++++++
 tb/tb_instruction_encoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared types and opcode constants for the instruction encoder and its FIFO.
// alu_decode() maps an ALU operation to its kind group and funct3/funct7 fields.
package instruction_encoder_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] instruction_t;

    typedef enum logic [2:0] {
        KIND_R,
        KIND_I,
        KIND_LOAD,
        KIND_S,
        KIND_U,
        KIND_AUIPC,
        KIND_B,
        KIND_HALT
    } encode_kind_t;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_ADDI,
        ALU_SLTI,
        ALU_XORI,
        ALU_ORI,
        ALU_ANDI,
        ALU_SLLI,
        ALU_SRLI,
        ALU_SRAI,
        ALU_BEQ,
        ALU_BNE,
        ALU_BLT,
        ALU_BGE
    } alu_instruction_t;

    // Opcode classes; bit 6 of the final opcode comes from in_scalar.
    localparam logic [5:0] OPCODE_R     = 6'b110011;
    localparam logic [5:0] OPCODE_I     = 6'b010011;
    localparam logic [5:0] OPCODE_LOAD  = 6'b000011;
    localparam logic [5:0] OPCODE_S     = 6'b100011;
    localparam logic [5:0] OPCODE_U     = 6'b110111;
    localparam logic [5:0] OPCODE_AUIPC = 6'b010111;
    localparam logic [5:0] OPCODE_B     = 6'b101011;
    localparam logic [5:0] OPCODE_HALT  = 6'b001011;

    // Loads and stores are always word-width accesses.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ALU_GROUP_R,
        ALU_GROUP_I,
        ALU_GROUP_B,
        ALU_GROUP_NONE
    } alu_group_t;

    typedef struct packed {
        alu_group_t  alu_group;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        is_shift;
    } alu_info_t;

    function automatic alu_info_t alu_decode(input alu_instruction_t alu);
        alu_info_t info;
        info.alu_group = ALU_GROUP_NONE;
        info.funct3    = 3'b000;
        info.funct7    = 7'b0000000;
        info.is_shift  = 1'b0;
        case (alu)
            ALU_ADD:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b000; end
            ALU_SUB:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b000; info.funct7 = FUNCT7_ALT; end
            ALU_SLL:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b001; end
            ALU_SLT:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b010; end
            ALU_XOR:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b100; end
            ALU_SRL:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b101; end
            ALU_SRA:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b101; info.funct7 = FUNCT7_ALT; end
            ALU_OR:   begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b110; end
            ALU_AND:  begin info.alu_group = ALU_GROUP_R; info.funct3 = 3'b111; end
            ALU_ADDI: begin info.alu_group = ALU_GROUP_I; info.funct3 = 3'b000; end
            ALU_SLTI: begin info.alu_group = ALU_GROUP_I; info.funct3 = 3'b010; end
            ALU_XORI: begin info.alu_group = ALU_GROUP_I; info.funct3 = 3'b100; end
            ALU_ORI:  begin info.alu_group = ALU_GROUP_I; info.funct3 = 3'b110; end
            ALU_ANDI: begin info.alu_group = ALU_GROUP_I; info.funct3 = 3'b111; end
            ALU_SLLI: begin info.alu_group = ALU_GROUP_I; info.funct3 = 3'b001; info.is_shift = 1'b1; end
            ALU_SRLI: begin info.alu_group = ALU_GROUP_I; info.funct3 = 3'b101; info.is_shift = 1'b1; end
            ALU_SRAI: begin
                info.alu_group = ALU_GROUP_I;
                info.funct3    = 3'b101;
                info.funct7    = FUNCT7_ALT;
                info.is_shift  = 1'b1;
            end
            ALU_BEQ:  begin info.alu_group = ALU_GROUP_B; info.funct3 = 3'b000; end
            ALU_BNE:  begin info.alu_group = ALU_GROUP_B; info.funct3 = 3'b001; end
            ALU_BLT:  begin info.alu_group = ALU_GROUP_B; info.funct3 = 3'b100; end
            ALU_BGE:  begin info.alu_group = ALU_GROUP_B; info.funct3 = 3'b101; end
            default:  info.alu_group = ALU_GROUP_NONE;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Two-entry FIFO of encoded words tagged with their program address.
// Push and pop may happen in the same cycle; contents clear on reset.
module encoder_fifo
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  instruction_t          push_instruction,
    input  logic [ADDR_WIDTH-1:0] push_address,
    input  logic                  pop,
    output logic [1:0]            count,
    output instruction_t          head_instruction,
    output logic [ADDR_WIDTH-1:0] head_address
);

    logic [1:0]            count_reg;
    logic [1:0]            count_next;
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic                  push_ok;
    logic                  pop_ok;
    instruction_t          entry_instruction [2];
    logic [ADDR_WIDTH-1:0] entry_address [2];

    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && (count_reg != 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            instruction_t          instruction_reg;
            logic [ADDR_WIDTH-1:0] address_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    instruction_reg <= '0;
                    address_reg     <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    instruction_reg <= push_instruction;
                    address_reg     <= push_address;
                end
            end

            assign entry_instruction[gi] = instruction_reg;
            assign entry_address[gi]     = address_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push_ok) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    assign count            = count_reg;
    assign head_instruction = entry_instruction[rd_ptr_reg];
    assign head_address     = entry_address[rd_ptr_reg];

endmodule

// File: rtl/instruction_encoder.sv
// Encodes structured instruction requests into 32-bit words, tags each with a
// program address and streams them out through a 2-entry FIFO until HALT.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  encode_kind_t          in_kind,
    input  alu_instruction_t      in_alu,
    input  logic                  in_scalar,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  data_t                 in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output instruction_t          out_instruction,
    output logic [ADDR_WIDTH-1:0] out_address,
    output logic                  done,
    output logic                  error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  error_reg;

    alu_info_t             info;
    instruction_t          word;
    logic                  legal;
    logic                  imm_fits12;
    logic                  imm_fits13;
    logic                  accept;
    logic                  push;
    logic                  reject;
    logic                  start_ok;
    logic                  pop;
    logic [1:0]            fifo_count;
    instruction_t          head_instruction;
    logic [ADDR_WIDTH-1:0] head_address;

    assign imm_fits12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign imm_fits13 = (in_imm[31:12] == {20{in_imm[12]}});

    always_comb begin
        info  = alu_decode(in_alu);
        word  = '0;
        legal = 1'b0;
        case (in_kind)
            KIND_R: begin
                legal = (info.alu_group == ALU_GROUP_R);
                word  = {info.funct7, in_rs2, in_rs1, info.funct3, in_rd, in_scalar, OPCODE_R};
            end
            KIND_I: begin
                if (info.is_shift) begin
                    // Shift amount is checked as unsigned, so negative values are rejected too.
                    legal = (info.alu_group == ALU_GROUP_I) && (in_imm <= 32'd31);
                    word  = {info.funct7, in_imm[4:0], in_rs1, info.funct3, in_rd, in_scalar, OPCODE_I};
                end else begin
                    legal = (info.alu_group == ALU_GROUP_I) && imm_fits12;
                    word  = {in_imm[11:0], in_rs1, info.funct3, in_rd, in_scalar, OPCODE_I};
                end
            end
            KIND_LOAD: begin
                legal = imm_fits12;
                word  = {in_imm[11:0], in_rs1, FUNCT3_WORD, in_rd, in_scalar, OPCODE_LOAD};
            end
            KIND_S: begin
                legal = imm_fits12;
                word  = {in_imm[11:5], in_rs2, in_rs1, FUNCT3_WORD, in_imm[4:0], in_scalar, OPCODE_S};
            end
            KIND_B: begin
                legal = (info.alu_group == ALU_GROUP_B) && imm_fits13 && !in_imm[0];
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, info.funct3,
                         in_imm[4:1], in_imm[11], in_scalar, OPCODE_B};
            end
            KIND_U: begin
                legal = (in_imm[11:0] == 12'd0);
                word  = {in_imm[31:12], in_rd, in_scalar, OPCODE_U};
            end
            KIND_AUIPC: begin
                legal = (in_imm[11:0] == 12'd0);
                word  = {in_imm[31:12], in_rd, in_scalar, OPCODE_AUIPC};
            end
            KIND_HALT: begin
                legal = 1'b1;
                word  = {26'd0, OPCODE_HALT};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    assign in_ready = (state_reg == ST_RUN) && (fifo_count < 2'd2);
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign reject   = accept && !legal;
    assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign pop      = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (push && (in_kind == KIND_HALT)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == 2'd0) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                addr_reg  <= base_address;
                error_reg <= 1'b0;
            end else begin
                if (push) begin
                    addr_reg <= addr_reg + ADDR_WIDTH'(1);
                end
                if (reject) begin
                    error_reg <= 1'b1;
                end
            end
        end
    end

    encoder_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .push_instruction (word),
        .push_address     (addr_reg),
        .pop              (pop),
        .count            (fifo_count),
        .head_instruction (head_instruction),
        .head_address     (head_address)
    );

    // Outputs read as zero whenever no word is queued.
    assign out_valid       = (fifo_count != 2'd0);
    assign out_instruction = out_valid ? head_instruction : '0;
    assign out_address     = out_valid ? head_address : '0;
    assign done            = (state_reg == ST_DONE);
    assign error           = error_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench: a table of single encodes plus hand-written sequences for
// backpressure, HALT/drain, address wrap and mid-operation reset.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic             clk;
    logic             reset;
    logic             start;
    logic [7:0]       base_address;
    logic             in_valid;
    logic             in_ready;
    encode_kind_t     in_kind;
    alu_instruction_t in_alu;
    logic             in_scalar;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    data_t            in_imm;
    logic             out_valid;
    logic             out_ready;
    instruction_t     out_instruction;
    logic [7:0]       out_address;
    logic             done;
    logic             error;

    int pass_cnt = 0;
    int total_cnt = 0;

    instruction_encoder #(.ADDR_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_address    (base_address),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_kind         (in_kind),
        .in_alu          (in_alu),
        .in_scalar       (in_scalar),
        .in_rd           (in_rd),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_imm          (in_imm),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_address     (out_address),
        .done            (done),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        encode_kind_t     kind;
        alu_instruction_t alu;
        logic             scalar;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        data_t            imm;
        logic             ok;
        instruction_t     word;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive_req(input vec_t v);
        in_kind   = v.kind;
        in_alu    = v.alu;
        in_scalar = v.scalar;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
    endtask

    task automatic drive_addi(input logic [4:0] rd, input data_t imm);
        in_kind   = KIND_I;
        in_alu    = ALU_ADDI;
        in_scalar = 1'b0;
        in_rd     = rd;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_imm    = imm;
    endtask

    task automatic pulse_start(input logic [7:0] base);
        start        = 1'b1;
        base_address = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue HALT with out_ready high and wait (bounded) for DONE.
    task automatic run_halt(input logic [7:0] exp_addr);
        int n;
        in_kind   = KIND_HALT;
        in_alu    = ALU_ADD;
        in_scalar = 1'b0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_imm    = 32'd0;
        in_valid  = 1'b1;
        chk("halt_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("halt_out_valid", out_valid, 1);
        chk("halt_word", out_instruction, 32'h0000000B);
        chk("halt_addr", out_address, exp_addr);
        chk("drain_in_ready", in_ready, 0);
        chk("drain_done", done, 0);
        $display("halt addr=%h word=%h", out_address, out_instruction);
        n = 0;
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("done_set", done, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 0);
    endtask

    initial begin
        vecs[0]  = '{KIND_R,     ALU_ADD,  1'b0, 5'd1, 5'd2, 5'd3, 32'h00000000, 1'b1, 32'h003100B3};
        vecs[1]  = '{KIND_R,     ALU_ADD,  1'b1, 5'd1, 5'd2, 5'd3, 32'h00000000, 1'b1, 32'h003100F3};
        vecs[2]  = '{KIND_R,     ALU_SUB,  1'b0, 5'd5, 5'd6, 5'd7, 32'h00000000, 1'b1, 32'h407302B3};
        vecs[3]  = '{KIND_I,     ALU_ADDI, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF10093};
        vecs[4]  = '{KIND_I,     ALU_ADDI, 1'b0, 5'd1, 5'd2, 5'd0, 32'h00000800, 1'b0, 32'h00000000};
        vecs[5]  = '{KIND_I,     ALU_SRAI, 1'b0, 5'd3, 5'd4, 5'd0, 32'h00000005, 1'b1, 32'h40525193};
        vecs[6]  = '{KIND_I,     ALU_SLLI, 1'b0, 5'd3, 5'd4, 5'd0, 32'h00000020, 1'b0, 32'h00000000};
        vecs[7]  = '{KIND_B,     ALU_BNE,  1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE209EAB};
        vecs[8]  = '{KIND_B,     ALU_BNE,  1'b0, 5'd0, 5'd1, 5'd2, 32'h00000003, 1'b0, 32'h00000000};
        vecs[9]  = '{KIND_R,     ALU_ADDI, 1'b0, 5'd1, 5'd2, 5'd3, 32'h00000000, 1'b0, 32'h00000000};
        vecs[10] = '{KIND_S,     ALU_ADD,  1'b0, 5'd0, 5'd2, 5'd3, 32'hFFFFFFF8, 1'b1, 32'hFE312C23};
        vecs[11] = '{KIND_LOAD,  ALU_ADD,  1'b0, 5'd4, 5'd5, 5'd0, 32'h000007FF, 1'b1, 32'h7FF2A203};
        vecs[12] = '{KIND_U,     ALU_ADD,  1'b0, 5'd6, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345337};
        vecs[13] = '{KIND_AUIPC, ALU_ADD,  1'b0, 5'd1, 5'd0, 5'd0, 32'h00001001, 1'b0, 32'h00000000};
        vecs[14] = '{KIND_AUIPC, ALU_ADD,  1'b1, 5'd1, 5'd0, 5'd0, 32'hFFFFF000, 1'b1, 32'hFFFFF0D7};
        vecs[15] = '{KIND_LOAD,  ALU_ADD,  1'b0, 5'd4, 5'd5, 5'd0, 32'hFFFFF7FF, 1'b0, 32'h00000000};
        vecs[16] = '{KIND_S,     ALU_ADD,  1'b0, 5'd0, 5'd0, 5'd0, 32'h000007FF, 1'b1, 32'h7E002FA3};
    end

    initial begin
        logic [7:0] exp_addr;
        logic       err_model;

        reset        = 1'b0;
        start        = 1'b0;
        base_address = 8'h00;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        drive_addi(5'd0, 32'd0);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_out_instruction", out_instruction, 32'h0);
        chk("rst_out_address", out_address, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // Table of single encodes, one word in flight at a time.
        pulse_start(8'h10);
        exp_addr  = 8'h10;
        err_model = 1'b0;
        for (int i = 0; i < NV; i++) begin
            drive_req(vecs[i]);
            in_valid = 1'b1;
            chk("vec_in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            chk("vec_out_valid", out_valid, vecs[i].ok);
            if (vecs[i].ok) begin
                chk("vec_word", out_instruction, vecs[i].word);
                chk("vec_addr", out_address, exp_addr);
                exp_addr = exp_addr + 8'd1;
            end else begin
                err_model = 1'b1;
            end
            chk("vec_error", error, err_model);
            $display("vec %0d kind=%0d imm=%h out_valid=%0b word=%h addr=%h error=%0b",
                     i, vecs[i].kind, vecs[i].imm, out_valid, out_instruction, out_address, error);
            @(negedge clk);
        end

        // start while running is ignored: address keeps counting, error stays set.
        pulse_start(8'h80);
        chk("run_start_error_kept", error, 1);
        run_halt(8'h1B);
        chk("done_error_kept", error, 1);

        // Backpressure: three pushes with out_ready low.
        pulse_start(8'h40);
        chk("restart_error_clear", error, 0);
        chk("restart_done_clear", done, 0);
        out_ready = 1'b0;
        drive_addi(5'd1, 32'd0);
        in_valid = 1'b1;
        chk("bp_ready0", in_ready, 1);
        @(negedge clk);
        drive_addi(5'd2, 32'd0);
        chk("bp_ready1", in_ready, 1);
        @(negedge clk);
        drive_addi(5'd3, 32'd0);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head0_word", out_instruction, 32'h00000093);
        chk("bp_head0_addr", out_address, 8'h40);
        @(negedge clk);
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        $display("bp pop word=%h addr=%h", out_instruction, out_address);
        @(negedge clk);
        chk("bp_head1_word", out_instruction, 32'h00000113);
        chk("bp_head1_addr", out_address, 8'h41);
        chk("bp_ready_after_pop", in_ready, 1);
        $display("bp pop word=%h addr=%h", out_instruction, out_address);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_head2_valid", out_valid, 1);
        chk("bp_head2_word", out_instruction, 32'h00000193);
        chk("bp_head2_addr", out_address, 8'h42);
        $display("bp pop word=%h addr=%h", out_instruction, out_address);
        @(negedge clk);
        chk("bp_empty", out_valid, 0);
        run_halt(8'h43);

        // Address wrap, then reset with two entries queued.
        pulse_start(8'hFF);
        out_ready = 1'b0;
        drive_addi(5'd1, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        drive_addi(5'd2, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("wrap_head0_addr", out_address, 8'hFF);
        chk("wrap_head0_word", out_instruction, 32'h00000093);
        out_ready = 1'b1;
        @(negedge clk);
        chk("wrap_head1_addr", out_address, 8'h00);
        chk("wrap_head1_word", out_instruction, 32'h00000113);
        $display("wrap word=%h addr=%h", out_instruction, out_address);
        out_ready = 1'b0;
        drive_addi(5'd3, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("prerst_full", in_ready, 0);
        chk("prerst_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_instruction", out_instruction, 32'h0);
        chk("midrst_out_address", out_address, 8'h00);
        chk("midrst_done", done, 0);
        $display("mid-op reset out_valid=%0b in_ready=%0b", out_valid, in_ready);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_idle_ready", in_ready, 0);
        chk("postrst_out_valid", out_valid, 0);
        pulse_start(8'h20);
        drive_addi(5'd7, 32'd5);
        in_valid = 1'b1;
        chk("resume_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("resume_word", out_instruction, 32'h00500393);
        chk("resume_addr", out_address, 8'h20);
        $display("resume word=%h addr=%h", out_instruction, out_address);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
